// File: rtl/axi_wr_burst_engine_pkg.sv
// Shared AXI write-path constants, FSM state encoding and size helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vdma_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_FIN
    } wr_state_e;

    // AXI awsize encoding: log2 of the bytes per beat
    function automatic logic [2:0] calc_awsize(input int dsize);
        return 3'($clog2(dsize / 8));
    endfunction

endpackage

// File: rtl/axi_wr_burst_engine_if.sv
// AXI4 write address/data/response channels between the burst engine and the interconnect.
// Latency: none (wiring only).
// Backpressure: awready/wready/bvalid from the slave, the usual valid/ready rules apply.
interface axi_wr_burst_engine_if #(
    parameter int ASIZE = 32,
    parameter int DSIZE = 64
);
    logic [ASIZE-1:0]   awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awvalid;
    logic               awready;
    logic [DSIZE-1:0]   wdata;
    logic [DSIZE/8-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_burst_engine_burst_splitter.sv
// Tracks remaining beats, current sub-burst size and the running write pointer.
// Latency: registered state, next sub-burst size/address available combinationally.
// Backpressure: none; advances only on load / aw_fire / b_fire strobes from the FSM.
module burst_splitter #(
    parameter int ASIZE     = 32,
    parameter int DSIZE     = 64,
    parameter int LSIZE     = 9,
    parameter int MAX_BURST = 256
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [LSIZE-1:0] req_len,
    input  logic             aw_fire,
    input  logic             b_fire,
    input  logic             frame_load,
    input  logic [ASIZE-1:0] frame_base,
    output logic [8:0]       next_beats,
    output logic             more,
    output logic [ASIZE-1:0] addr_next
);

    logic [LSIZE-1:0] remaining;
    logic [8:0]       beats;
    logic [ASIZE-1:0] pointer;
    logic [LSIZE-1:0] rem_after;
    logic [LSIZE-1:0] rem_src;

    // Beats still owed once the current sub-burst is acknowledged
    assign rem_after  = remaining - LSIZE'(beats);
    assign more       = (rem_after != '0);
    assign rem_src    = load ? req_len : rem_after;
    assign next_beats = (32'(rem_src) > MAX_BURST) ? 9'(MAX_BURST) : 9'(rem_src);
    // A frame reload in the same cycle as a request must win over the stale pointer
    assign addr_next  = frame_load ? frame_base : pointer;

    // Remaining/beats on request accept and on each response; pointer on each address accept
    always_ff @(posedge clock) begin
        if (rst) begin
            remaining <= '0;
            beats     <= '0;
            pointer   <= '0;
        end else begin
            if (load || b_fire) begin
                remaining <= rem_src;
                beats     <= next_beats;
            end
            if (frame_load) begin
                pointer <= frame_base;
            end else if (aw_fire) begin
                pointer <= pointer + ASIZE'(beats) * ASIZE'(DSIZE / 8);
            end
        end
    end

endmodule

// File: rtl/axi_wr_burst_engine.sv
// Splits burst/tail requests into AXI4 INCR write bursts fed from an FWFT line FIFO.
// Latency: resp and awvalid one cycle after request; done one cycle after the last B handshake.
// Backpressure: stalls on awready/wready/bvalid and on fifo_empty; one burst outstanding at a time.
module axi_wr_burst_engine
    import vdma_axi_pkg::*;
#(
    parameter int ASIZE     = 32,
    parameter int DSIZE     = 64,
    parameter int LSIZE     = 9,
    parameter int MAX_BURST = 256
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic [ASIZE-1:0]       frame_base,
    input  logic                   burst_req,
    input  logic                   tail_req,
    input  logic [LSIZE-1:0]       req_len,
    output logic                   resp,
    output logic                   done,
    input  logic [DSIZE-1:0]       fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   err,
    axi_wr_burst_engine_if.master  axi
);

    wr_state_e        state, state_nxt;
    logic [7:0]       beat_cnt;
    logic [ASIZE-1:0] awaddr_q;
    logic [7:0]       awlen_q;
    logic             fs_pend;
    logic             req, load, aw_fire, w_fire, b_fire, frame_load;
    logic [8:0]       next_beats;
    logic             more;
    logic [ASIZE-1:0] addr_next;

    assign req        = burst_req | tail_req;
    assign load       = (state == ST_IDLE) && req;
    assign aw_fire    = (state == ST_ADDR) && axi.awready;
    assign w_fire     = axi.wvalid && axi.wready;
    assign b_fire     = (state == ST_RESP) && axi.bvalid;
    // done waits one cycle behind resp so a zero-length request still sees them on separate cycles
    assign done       = (state == ST_FIN) && !resp;
    assign frame_load = ((state == ST_IDLE) && frame_start) ||
                        (done && (fs_pend || frame_start));

    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = calc_awsize(DSIZE);
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = (state == ST_ADDR);
    assign axi.wdata   = fifo_dout;
    assign axi.wstrb   = '1;
    assign axi.wvalid  = (state == ST_DATA) && !fifo_empty;
    assign axi.wlast   = (state == ST_DATA) && (beat_cnt == awlen_q);
    assign axi.bready  = (state == ST_RESP);
    assign fifo_rd_en  = w_fire;

    burst_splitter #(
        .ASIZE     (ASIZE),
        .DSIZE     (DSIZE),
        .LSIZE     (LSIZE),
        .MAX_BURST (MAX_BURST)
    ) u_splitter (
        .clock      (clock),
        .rst        (rst),
        .load       (load),
        .req_len    (req_len),
        .aw_fire    (aw_fire),
        .b_fire     (b_fire),
        .frame_load (frame_load),
        .frame_base (frame_base),
        .next_beats (next_beats),
        .more       (more),
        .addr_next  (addr_next)
    );

    // State register
    always_ff @(posedge clock) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one burst in flight, AW only after the previous B
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = (req_len == '0) ? ST_FIN : ST_ADDR;
            ST_ADDR: if (axi.awready) state_nxt = ST_DATA;
            ST_DATA: if (w_fire && axi.wlast) state_nxt = ST_RESP;
            ST_RESP: if (axi.bvalid) state_nxt = more ? ST_ADDR : ST_FIN;
            ST_FIN:  if (!resp) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address-channel payload, beat counter, resp pulse, sticky error and deferred frame reload
    always_ff @(posedge clock) begin
        if (rst) begin
            resp     <= 1'b0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
            fs_pend  <= 1'b0;
        end else begin
            resp <= load;
            if ((load && req_len != '0) || (b_fire && more)) begin
                awaddr_q <= addr_next;
                awlen_q  <= 8'(next_beats - 9'd1);
            end
            if (aw_fire)     beat_cnt <= '0;
            else if (w_fire) beat_cnt <= beat_cnt + 8'd1;
            if (frame_load)                              err <= 1'b0;
            else if (b_fire && axi.bresp != RESP_OKAY)   err <= 1'b1;
            if (frame_load)                              fs_pend <= 1'b0;
            else if (frame_start && state != ST_IDLE)    fs_pend <= 1'b1;
        end
    end

endmodule
